load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: SB_DEPTH, default 4, number of store-buffer entries (power of two, 2..16).
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 req_valid  in  1  pipeline request present.
REQ-005 req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-008 req_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-009 req_addr  in  64  byte address.
REQ-010 req_wdata  in  64  store data, right-aligned in bits [8*size_bytes-1:0].
REQ-011 resp_valid  out  1  load result valid, one-cycle pulse.
REQ-012 resp_rdata  out  64  extended load result.
REQ-013 misalign  out  1  one-cycle pulse flagging a dropped misaligned request.
REQ-014 sb_busy  out  1  store buffer non-empty.
REQ-015 mem_read, mem_write  out  1 each  data-RAM strobes, never both high.
REQ-016 mem_addr  out  64  doubleword index = byte address >> 3.
REQ-017 mem_wdata  out  64  full doubleword to RAM.
REQ-018 mem_rdata  in  64  RAM read data, combinational from mem_addr while mem_read high.

Function
REQ-019 Misaligned = req_addr not a multiple of size bytes; request accepted, no state or buffer change, misalign=1 next cycle; a load also gives resp_valid=1, resp_rdata=0 that cycle.
REQ-020 Stores: req_ready = !full in every state; accepted entry {dword index, byte offset, size, data} visible in buffer next cycle; FIFO order preserved.
REQ-021 Loads: req_ready only in IDLE and when not hazard-stalled (REQ-027); accept at T, mem_read=1 with index at T+1 (state LOAD), resp_valid at T+2.
REQ-022 Load extract: little-endian, lane = mem_rdata >> (8*addr[2:0]), truncated to size, then sign/zero-extended to 64 bits.
REQ-023 States: IDLE, LOAD, DWR, RMW_RD, RMW_WR. IDLE->LOAD on load accept; IDLE->DWR (head size 11) or IDLE->RMW_RD (otherwise) when buffer non-empty and no load accepted; DWR, RMW_WR, LOAD -> IDLE.
REQ-024 DWR: mem_write=1, mem_wdata=head data, pop head at end of cycle.
REQ-025 RMW_RD: mem_read=1, capture mem_rdata; RMW_WR: mem_write=1, mem_wdata = captured data with head bytes replaced per offset/size mask, pop at end of cycle.
REQ-026 Load accept takes priority over starting a drain in the same IDLE cycle.
REQ-027 Without forwarding (REQ-031), a load stalls (req_ready=0) while sb_busy=1.
REQ-028 Simultaneous push and pop: count unchanged; full/empty from registered count only; pointers wrap modulo SB_DEPTH.
REQ-029 Outputs drive 0 in any state not stated above.

Reset
REQ-030 rst_n=0 at a rising edge: state IDLE, buffer emptied (pending stores discarded), resp_valid, misalign, mem_read, mem_write, sb_busy = 0, resp_rdata=0, effective the next cycle even mid-drain or mid-load.

Configuration
REQ-031 STORE_FWD_EN defined: load whose index matches no buffer entry proceeds despite sb_busy; youngest matching entry of size 11 forwards its data (resp_valid at T+1, no RAM access); any other match stalls until that entry drains. Undefined: REQ-027 applies, no forwarding logic built.

Verification
REQ-032 Store dword 0x1122334455667788 @0x10, load dword @0x10 unsigned -> mem_write idx 2 once, resp_rdata=0x1122334455667788.
REQ-033 RAM idx 1 = 0; store byte 0xAB @0x0B, load byte signed @0x0B -> RMW_RD then RMW_WR writes 0x00000000AB000000, resp_rdata=0xFFFFFFFFFFFFFFAB.
REQ-034 Five back-to-back stores with drain blocked by loads, SB_DEPTH=4 -> req_ready=0 on 5th until first pop, write order preserved.
REQ-035 Load half @0x03 -> misalign=1 and resp_valid=1 with 0 at T+1, no mem strobe.
REQ-036 With STORE_FWD_EN: store dword 0xDEAD @0x20 then load @0x20 -> resp_valid at T+1 with 0xDEAD, mem_read never high for idx 4.
REQ-037 rst_n=0 during RMW_WR with 3 entries queued -> next cycle sb_busy=0, mem_write=0, state IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: in-order store buffer drained to a doubleword RAM by direct or read-modify-write cycles.
// Optional build macro STORE_FWD_EN: dword stores forward to younger loads; partial-store hazards stall.

module load_store_unit #(
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        misalign,
  output logic        sb_busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(SB_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DWR    = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4
  } state_t;

  state_t        state_q, state_d;

  logic [60:0]   sb_idx_q  [SB_DEPTH];
  logic [2:0]    sb_off_q  [SB_DEPTH];
  logic [1:0]    sb_size_q [SB_DEPTH];
  logic [63:0]   sb_data_q [SB_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic [60:0]   ld_idx_q;
  logic [2:0]    ld_off_q;
  logic [1:0]    ld_size_q;
  logic          ld_signed_q;
  logic [63:0]   rmw_q;

  logic          resp_valid_q, resp_valid_d;
  logic [63:0]   resp_rdata_q, resp_rdata_d;
  logic          misalign_q, misalign_d;

  logic          empty_s, full_s, misaligned_s, req_ready_s;
  logic          acc_s, ld_acc_s, push_s, pop_s;
  logic          match_s, fwd_ok_s, stall_s, fwd_hit_s;
  logic [63:0]   fwd_data_s;
  logic [63:0]   mask_s, merge_data_s;
  logic          mem_read_s, mem_write_s;
  logic [63:0]   mem_addr_s, mem_wdata_s;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] extract_load(input logic [63:0] dw, input logic [2:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic [63:0] lane;
    lane = dw >> {off, 3'b000};
    case (size)
      2'b00:   extract_load = {{56{sgn & lane[7]}}, lane[7:0]};
      2'b01:   extract_load = {{48{sgn & lane[15]}}, lane[15:0]};
      2'b10:   extract_load = {{32{sgn & lane[31]}}, lane[31:0]};
      default: extract_load = lane;
    endcase
  endfunction

  assign empty_s = (count_q == {CW{1'b0}});
  assign full_s  = (count_q == FULL_CNT);

  // Alignment check: address must be a multiple of the access size.
  always_comb begin
    case (req_size)
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = req_addr[0];
      2'b10:   misaligned_s = |req_addr[1:0];
      default: misaligned_s = |req_addr[2:0];
    endcase
  end

`ifdef STORE_FWD_EN
  logic [PW-1:0] scan_pos_s;
  logic          scan_hit_s;

  // Oldest-to-youngest scan so the youngest matching entry decides forward vs stall.
  always_comb begin
    match_s    = 1'b0;
    fwd_ok_s   = 1'b0;
    fwd_data_s = 64'h0;
    scan_pos_s = head_q;
    scan_hit_s = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      scan_pos_s = head_q + i[PW-1:0];
      scan_hit_s = (count_q > i[CW-1:0]) && (sb_idx_q[scan_pos_s] == req_addr[63:3]);
      match_s    = match_s | scan_hit_s;
      fwd_ok_s   = scan_hit_s ? (sb_size_q[scan_pos_s] == 2'b11) : fwd_ok_s;
      fwd_data_s = scan_hit_s ? sb_data_q[scan_pos_s] : fwd_data_s;
    end
  end
`else
  assign match_s    = ~empty_s;
  assign fwd_ok_s   = 1'b0;
  assign fwd_data_s = 64'h0;
`endif

  assign stall_s   = match_s & ~fwd_ok_s;
  assign fwd_hit_s = match_s & fwd_ok_s;

  // Stores only need buffer space; loads need the idle slot and no unresolved hazard.
  always_comb begin
    if (req_write) begin
      req_ready_s = ~full_s;
    end else begin
      req_ready_s = (state_q == S_IDLE) & ~stall_s;
    end
  end

  assign acc_s    = req_valid & req_ready_s;
  assign ld_acc_s = acc_s & ~req_write;
  assign push_s   = acc_s & req_write & ~misaligned_s;
  assign pop_s    = (state_q == S_DWR) || (state_q == S_RMW_WR);

  assign mask_s       = size_mask(sb_size_q[head_q]) << {sb_off_q[head_q], 3'b000};
  assign merge_data_s = (rmw_q & ~mask_s) |
                        ((sb_data_q[head_q] & size_mask(sb_size_q[head_q])) << {sb_off_q[head_q], 3'b000});

  // Next-state: a load accept beats starting a drain in the same idle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ld_acc_s) begin
          state_d = (misaligned_s || fwd_hit_s) ? S_IDLE : S_LOAD;
        end else if (!empty_s) begin
          state_d = (sb_size_q[head_q] == 2'b11) ? S_DWR : S_RMW_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RMW_RD: state_d = S_RMW_WR;
      S_LOAD, S_DWR, S_RMW_WR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM port decode from the current state.
  always_comb begin
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    mem_addr_s  = 64'h0;
    mem_wdata_s = 64'h0;
    case (state_q)
      S_LOAD: begin
        mem_read_s = 1'b1;
        mem_addr_s = {3'b000, ld_idx_q};
      end
      S_DWR: begin
        mem_write_s = 1'b1;
        mem_addr_s  = {3'b000, sb_idx_q[head_q]};
        mem_wdata_s = sb_data_q[head_q];
      end
      S_RMW_RD: begin
        mem_read_s = 1'b1;
        mem_addr_s = {3'b000, sb_idx_q[head_q]};
      end
      S_RMW_WR: begin
        mem_write_s = 1'b1;
        mem_addr_s  = {3'b000, sb_idx_q[head_q]};
        mem_wdata_s = merge_data_s;
      end
      default: mem_read_s = 1'b0;
    endcase
  end

  // Response next-state: misaligned store may coincide with a LOAD-state result.
  always_comb begin
    misalign_d   = acc_s & misaligned_s;
    resp_valid_d = 1'b0;
    resp_rdata_d = 64'h0;
    if (state_q == S_LOAD) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = extract_load(mem_rdata, ld_off_q, ld_size_q, ld_signed_q);
    end else if (ld_acc_s && misaligned_s) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = 64'h0;
    end else if (ld_acc_s && fwd_hit_s) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = extract_load(fwd_data_s, req_addr[2:0], req_size, req_signed);
    end else begin
      resp_valid_d = 1'b0;
      resp_rdata_d = 64'h0;
    end
  end

  // Control state, response registers and load/RMW capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'h0;
      misalign_q   <= 1'b0;
      ld_idx_q     <= 61'h0;
      ld_off_q     <= 3'b000;
      ld_size_q    <= 2'b00;
      ld_signed_q  <= 1'b0;
      rmw_q        <= 64'h0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      misalign_q   <= misalign_d;
      if (ld_acc_s) begin
        ld_idx_q    <= req_addr[63:3];
        ld_off_q    <= req_addr[2:0];
        ld_size_q   <= req_size;
        ld_signed_q <= req_signed;
      end
      if (state_q == S_RMW_RD) begin
        rmw_q <= mem_rdata;
      end
    end
  end

  // Buffer pointers and occupancy; payload validity is implied by count_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (push_s) tail_q <= tail_q + PTR_ONE;
      if (pop_s)  head_q <= head_q + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Store-buffer payload write.
  always_ff @(posedge clk) begin
    if (push_s) begin
      sb_idx_q[tail_q]  <= req_addr[63:3];
      sb_off_q[tail_q]  <= req_addr[2:0];
      sb_size_q[tail_q] <= req_size;
      sb_data_q[tail_q] <= req_wdata;
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign misalign   = misalign_q;
  assign sb_busy    = ~empty_s;
  assign mem_read   = mem_read_s;
  assign mem_write  = mem_write_s;
  assign mem_addr   = mem_addr_s;
  assign mem_wdata  = mem_wdata_s;

endmodule
